// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg
// Shared definitions for the memory port arbiter:
//   owner_t          - which requester owns the read data returning next cycle
//   AW_DEF/DW_DEF    - default word-address and data widths
//   STARVE_LIMIT_DEF - default lost-contention count before fetch is forced
//   word_index()     - byte address to word index (drops the byte offset)
package mem_arb_pkg;

  localparam int AW_DEF           = 12;
  localparam int DW_DEF           = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // The full shifted value is returned so callers can truncate to their own
  // address width; truncation is what makes out-of-range addresses wrap.
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch port (i_*), the data port (d_*) and the memory port (m_*)
// of the arbiter.
//   slave  modport - the arbiter's view: requests and m_rdata in, grants,
//                    responses and memory controls out
//   master modport - the environment's view (pipeline stages plus RAM)
// Parameters: AW word-address width, DW data width.
interface mem_port_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 32
);

  logic          i_req;
  logic [31:0]   i_addr;
  logic          i_flush;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [31:0]   d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, i_flush,
    input  d_req, d_we, d_addr, d_wdata,
    input  m_rdata,
    output i_gnt, i_rvalid, i_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, i_flush,
    output d_req, d_we, d_addr, d_wdata,
    output m_rdata,
    input  i_gnt, i_rvalid, i_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_starve_cnt.sv
// arb_starve_cnt
// Counts contention cycles that fetch has lost since its last grant and raises
// force_o once the count reaches LIMIT, so fetch cannot starve forever.
// Only part of the fairness build (macro ARB_FAIR_EN).
//   clk, reset_n - clock, asynchronous active-low reset
//   inc          - fetch lost a contention cycle
//   clr          - fetch was granted (any reason)
//   force_o      - fetch must win the next contention cycle
`ifdef ARB_FAIR_EN
module arb_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic force_o
);

  logic [3:0] cnt_q;

  // Saturating 4-bit counter; clear has priority because a forced fetch
  // grant is also the event that ends the starvation window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 4'd0;
    end else if (clr) begin
      cnt_q <= 4'd0;
    end else if (inc && (cnt_q != 4'hF)) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign force_o = (cnt_q == 4'(LIMIT));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous-read RAM between the fetch port and the
// data (load/store) port. Grants are combinational in the request cycle; read
// data returns one cycle later straight from m_rdata, qualified by the owner's
// rvalid strobe.
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - mem_port_arbiter_if.slave: fetch, data and memory ports
// Build option: ARB_FAIR_EN adds the starvation counter so fetch wins one
// contention cycle after STARVE_LIMIT consecutive losses; without it data
// always wins contention.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_port_arbiter_if.slave   bus
);

  logic   i_gnt_c;
  logic   d_gnt_c;
  logic   force_i;
  owner_t owner_q;
  owner_t owner_d;

`ifdef ARB_FAIR_EN
  logic contention;

  assign contention = bus.i_req & bus.d_req;

  arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (contention & ~i_gnt_c),
    .clr     (i_gnt_c),
    .force_o (force_i)
  );
`else
  assign force_i = 1'b0;
`endif

  // Grant selection. Data wins contention unless the starvation counter is
  // forcing fetch through. Grants are held low while in reset.
  always_comb begin
    i_gnt_c = 1'b0;
    d_gnt_c = 1'b0;
    if (reset_n) begin
      if (bus.d_req && !(bus.i_req && force_i)) begin
        d_gnt_c = 1'b1;
      end else if (bus.i_req) begin
        i_gnt_c = 1'b1;
      end
    end
  end

  // Next owner of the returning read data; stores need no response.
  always_comb begin
    owner_d = OWN_NONE;
    if (i_gnt_c) begin
      owner_d = OWN_I;
    end else if (d_gnt_c && !bus.d_we) begin
      owner_d = OWN_D;
    end
  end

  // Owner register; reset drops any pending response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign bus.i_gnt   = i_gnt_c;
  assign bus.d_gnt   = d_gnt_c;
  assign bus.m_en    = i_gnt_c | d_gnt_c;
  assign bus.m_we    = d_gnt_c & bus.d_we;
  assign bus.m_addr  = d_gnt_c ? AW'(word_index(bus.d_addr)) : AW'(word_index(bus.i_addr));
  assign bus.m_wdata = bus.d_wdata;

  // A flush kills only the fetch whose data is returning now; a fetch granted
  // in the same cycle lands in owner_q afterwards and is unaffected.
  assign bus.i_rvalid = (owner_q == OWN_I) & ~bus.i_flush;
  assign bus.d_rvalid = (owner_q == OWN_D);
  assign bus.i_rdata  = bus.m_rdata;
  assign bus.d_rdata  = bus.m_rdata;

endmodule
